// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_core
// Purpose  : Single-clock FIFO with registered read data and valid strobe,
//            full/empty/almost flags, occupancy count and sticky error capture.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter int WORDSIZE = 8,
    parameter int ADDRSIZE = 8,
    parameter int AF_LEVEL = 2**ADDRSIZE - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [WORDSIZE-1:0] wdata,
    input  logic                rinc,
    input  logic                clr_err,
    output logic [WORDSIZE-1:0] rdata,
    output logic                rvalid,
    output logic                wfull,
    output logic                rempty,
    output logic                walmost_full,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);

    localparam int              c_DEPTH = 2**ADDRSIZE;
    localparam logic [ADDRSIZE:0] c_AF  = (ADDRSIZE+1)'(AF_LEVEL);
    localparam logic [ADDRSIZE:0] c_AE  = (ADDRSIZE+1)'(AE_LEVEL);
    localparam logic [ADDRSIZE:0] c_ONE = (ADDRSIZE+1)'(1);

    logic [WORDSIZE-1:0] mem_q [c_DEPTH];

    logic [ADDRSIZE:0]   wptr_q, wptr_d;
    logic [ADDRSIZE:0]   rptr_q, rptr_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                w_wr_en;
    logic                w_rd_en;
    logic [ADDRSIZE:0]   w_count;
    logic                w_full;
    logic                w_empty;

    // Flags decode only from registered pointers, never from the requests.
    assign w_count = wptr_q - rptr_q;
    assign w_empty = (wptr_q == rptr_q);
    assign w_full  = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                     (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);

    assign w_wr_en = winc && !w_full;
    assign w_rd_en = rinc && !w_empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (w_wr_en) begin
            wptr_d = wptr_q + c_ONE;
        end
        if (w_rd_en) begin
            rptr_d   = rptr_q + c_ONE;
            rdata_d  = mem_q[rptr_q[ADDRSIZE-1:0]];
            rvalid_d = 1'b1;
        end

        // A new offence beats a concurrent clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (winc && w_full) begin
            overflow_d = 1'b1;
        end
        if (rinc && w_empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a write during reset is simply dropped.
    always_ff @(posedge wclk) begin
        if (!wrst && w_wr_en) begin
            mem_q[wptr_q[ADDRSIZE-1:0]] <= wdata;
        end
    end

    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign wfull         = w_full;
    assign rempty        = w_empty;
    assign walmost_full  = (w_count >= c_AF);
    assign ralmost_empty = (w_count <= c_AE);
    assign count         = w_count;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_core
// Purpose  : Directed self-checking bench for sync_fifo_core (depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_core;

    localparam int c_W  = 8;
    localparam int c_A  = 2;

    logic           wclk = 1'b0;
    logic           wrst = 1'b0;
    logic           winc = 1'b0;
    logic [c_W-1:0] wdata = '0;
    logic           rinc = 1'b0;
    logic           clr_err = 1'b0;
    logic [c_W-1:0] rdata;
    logic           rvalid;
    logic           wfull;
    logic           rempty;
    logic           walmost_full;
    logic           ralmost_empty;
    logic [c_A:0]   count;
    logic           overflow;
    logic           underflow;

    int errors = 0;
    int checks = 0;

    sync_fifo_core #(
        .WORDSIZE(c_W), .ADDRSIZE(c_A), .AF_LEVEL(3), .AE_LEVEL(1)
    ) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wdata(wdata), .rinc(rinc),
        .clr_err(clr_err), .rdata(rdata), .rvalid(rvalid), .wfull(wfull),
        .rempty(rempty), .walmost_full(walmost_full), .ralmost_empty(ralmost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 wclk = ~wclk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic idle_inputs();
        winc = 1'b0; rinc = 1'b0; clr_err = 1'b0; wrst = 1'b0;
    endtask

    task automatic fill4(input logic [7:0] base);
        for (int i = 0; i < 4; i++) begin
            winc = 1'b1; wdata = base + 8'(i * 8'h11);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        wrst = 1'b1; winc = 1'b1; rinc = 1'b1;
        step();
        idle_inputs();
        checks++;
        if ({count, rempty, wfull, walmost_full, ralmost_empty, rvalid, rdata, overflow, underflow}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b af=%b ae=%b rv=%b rdata=%h ov=%b un=%b, need 0 1 0 0 1 0 00 0 0",
                     count, rempty, wfull, walmost_full, ralmost_empty, rvalid, rdata, overflow, underflow);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            winc = 1'b1; wdata = 8'h11 * 8'(i + 1);
            step();
            checks++;
            if ({count, walmost_full, wfull, ralmost_empty, rempty} !==
                {3'(i + 1), (i + 1 >= 3), (i == 3), (i + 1 <= 1), 1'b0}) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d af=%b full=%b ae=%b empty=%b, need count=%0d af=%b full=%b ae=%b empty=0",
                         i, count, walmost_full, wfull, ralmost_empty, rempty,
                         i + 1, (i + 1 >= 3), (i == 3), (i + 1 <= 1));
            end
        end
        winc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            step();
            exp = 8'h11 * 8'(i + 1);
            checks++;
            if ({rvalid, rdata, count} !== {1'b1, exp, 3'(3 - i)}) begin
                errors++;
                $display("FAIL drain_%0d: rvalid=%b rdata=%h count=%0d, need 1 %h %0d",
                         i, rvalid, rdata, count, exp, 3 - i);
            end
        end
        rinc = 1'b0;
        step();
        checks++;
        if ({rvalid, rempty, rdata, underflow} !== {1'b0, 1'b1, 8'h44, 1'b0}) begin
            errors++;
            $display("FAIL drain_end: rvalid=%b empty=%b rdata=%h un=%b, need 0 1 44 0",
                     rvalid, rempty, rdata, underflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        fill4(8'h11);
        winc = 1'b1; wdata = 8'h55;
        step();
        winc = 1'b0;
        checks++;
        if ({overflow, count, wfull} !== {1'b1, 3'd4, 1'b1}) begin
            errors++;
            $display("FAIL overflow_set: ov=%b count=%0d full=%b, need 1 4 1", overflow, count, wfull);
        end
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            step();
            exp = 8'h11 + 8'(i * 8'h11);
            checks++;
            if ({rvalid, rdata} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL overflow_read_%0d: rvalid=%b rdata=%h, need 1 %h", i, rvalid, rdata, exp);
            end
        end
        rinc = 1'b0;
        step();
        checks++;
        if ({rempty, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_sticky: empty=%b ov=%b, need 1 1", rempty, overflow);
        end
    endtask

    task automatic test_clr_err();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err_clear: ov=%b, need 0", overflow);
        end
        fill4(8'h01);
        winc = 1'b1; wdata = 8'hEE; clr_err = 1'b1;
        step();
        checks++;
        if ({overflow, count} !== {1'b1, 3'd4}) begin
            errors++;
            $display("FAIL clr_err_set_priority: ov=%b count=%0d, need 1 4", overflow, count);
        end
        winc = 1'b0;
        step();
        clr_err = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_err_second: ov=%b, need 0", overflow);
        end
        rinc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        rinc = 1'b0;
        step();
        checks++;
        if ({rempty, rdata} !== {1'b1, 8'h34}) begin
            errors++;
            $display("FAIL clr_err_drain: empty=%b rdata=%h, need 1 34", rempty, rdata);
        end
    endtask

    task automatic test_underflow();
        winc = 1'b1; rinc = 1'b1; wdata = 8'hA5;
        step();
        idle_inputs();
        checks++;
        if ({count, underflow, rvalid} !== {3'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL underflow_simul: count=%0d un=%b rvalid=%b, need 1 1 0", count, underflow, rvalid);
        end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++;
        if ({rvalid, rdata, count} !== {1'b1, 8'hA5, 3'd0}) begin
            errors++;
            $display("FAIL underflow_read: rvalid=%b rdata=%h count=%0d, need 1 a5 0", rvalid, rdata, count);
        end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_clear: un=%b, need 0", underflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        winc = 1'b1; wdata = 8'h80; step();
        wdata = 8'h81; step();
        for (int k = 0; k < 10; k++) begin
            winc = 1'b1; rinc = 1'b1; wdata = 8'h82 + 8'(k);
            step();
            exp = 8'h80 + 8'(k);
            checks++;
            if ({rvalid, rdata, count} !== {1'b1, exp, 3'd2}) begin
                errors++;
                $display("FAIL b2b_%0d: rvalid=%b rdata=%h count=%0d, need 1 %h 2", k, rvalid, rdata, count, exp);
            end
        end
        winc = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            exp = 8'h8A + 8'(k);
            checks++;
            if ({rvalid, rdata} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b_tail_%0d: rvalid=%b rdata=%h, need 1 %h", k, rvalid, rdata, exp);
            end
        end
        rinc = 1'b0;
        step();
        checks++;
        if ({rempty, overflow, underflow} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_end: empty=%b ov=%b un=%b, need 1 0 0", rempty, overflow, underflow);
        end
    endtask

    task automatic test_mid_reset();
        fill4(8'h21);
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++;
        if ({count, rvalid, rdata} !== {3'd3, 1'b1, 8'h21}) begin
            errors++;
            $display("FAIL midrst_pre: count=%0d rvalid=%b rdata=%h, need 3 1 21", count, rvalid, rdata);
        end
        wrst = 1'b1; winc = 1'b1; rinc = 1'b1; wdata = 8'h99;
        step();
        idle_inputs();
        checks++;
        if ({count, rempty, wfull, walmost_full, ralmost_empty, rvalid, rdata, overflow, underflow}
            !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_state: count=%0d empty=%b full=%b af=%b ae=%b rv=%b rdata=%h ov=%b un=%b, need 0 1 0 0 1 0 00 0 0",
                     count, rempty, wfull, walmost_full, ralmost_empty, rvalid, rdata, overflow, underflow);
        end
        winc = 1'b1; wdata = 8'h77;
        step();
        winc = 1'b0; rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++;
        if ({rvalid, rdata, rempty} !== {1'b1, 8'h77, 1'b1}) begin
            errors++;
            $display("FAIL midrst_new_data: rvalid=%b rdata=%h empty=%b, need 1 77 1", rvalid, rdata, rempty);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_clr_err();
        test_underflow();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
